// File: rtl/overload_pkg.sv
// Shared definitions for the elevator overload supervisor:
// state encoding, default thresholds and the saturating load update.
package overload_pkg;

   localparam int LOAD_W  = 4;
   localparam int CNT_W   = 8;
   localparam int STATE_W = 3;

   localparam int MAX_LOAD_DEF          = 6;
   localparam int ALARM_HALF_PERIOD_DEF = 4;
   localparam int SETTLE_CYCLES_DEF     = 3;

   localparam logic [STATE_W-1:0] S_BOARDING = 3'd0;
   localparam logic [STATE_W-1:0] S_READY    = 3'd1;
   localparam logic [STATE_W-1:0] S_OVERLOAD = 3'd2;
   localparam logic [STATE_W-1:0] S_SETTLE   = 3'd3;
   localparam logic [STATE_W-1:0] S_MOVING   = 3'd4;

   // One add and one remove cancel; the count sticks at 0 and at full scale.
   function automatic logic [LOAD_W-1:0] sat_step(input logic [LOAD_W-1:0] cur,
                                                  input logic              add,
                                                  input logic              rem);
      logic [LOAD_W-1:0] res;
      res = cur;
      if (add && !rem && (cur != '1)) begin
         res = cur + 1'b1;
      end else if (rem && !add && (cur != '0)) begin
         res = cur - 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector: pulse is high for one cycle,
// the cycle after the input is first sampled high.
module edge_pulse (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic pulse
);

   logic prev_q;
   logic pulse_q;

   // Keep the previous level and flag a 0->1 transition
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         prev_q  <= in;
         pulse_q <= in & ~prev_q;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/overload_supervisor.sv
// Elevator overload supervisor: tracks car load from flip inputs, holds the
// doors and blinks the buzzer while overloaded, and grants departure only
// from a settled, closed-door READY state.
module overload_supervisor
   import overload_pkg::*;
#(
   parameter int MAX_LOAD          = MAX_LOAD_DEF,
   parameter int ALARM_HALF_PERIOD = ALARM_HALF_PERIOD_DEF,
   parameter int SETTLE_CYCLES     = SETTLE_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              weight_flip,
   input  logic              unload_flip,
   input  logic              door_closed,
   input  logic              depart_req,
   input  logic              motion_done,
   output logic [LOAD_W-1:0] load_count,
   output logic              weight_limit_exceeded,
   output logic              alarm,
   output logic              door_hold,
   output logic              depart_grant
);

   localparam logic [LOAD_W-1:0] MAX_LOAD_C  = LOAD_W'(MAX_LOAD);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST   = CNT_W'(ALARM_HALF_PERIOD - 1);

   logic               add_pulse;
   logic               rem_pulse;
   logic               over_limit;

   logic [STATE_W-1:0] state_q,     state_d;
   logic [LOAD_W-1:0]  load_q,      load_d;
   logic [CNT_W-1:0]   settle_q,    settle_d;
   logic [CNT_W-1:0]   alarm_cnt_q, alarm_cnt_d;
   logic               alarm_q,     alarm_d;
   logic               limit_q,     limit_d;
   logic               grant_q,     grant_d;

   edge_pulse u_edge_add (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (weight_flip),
      .pulse (add_pulse)
   );

   edge_pulse u_edge_rem (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (unload_flip),
      .pulse (rem_pulse)
   );

   assign over_limit = (load_q > MAX_LOAD_C);

   // Load count follows detected edges except while the car is moving
   always_comb begin
      load_d = load_q;
      if (state_q != S_MOVING) begin
         load_d = sat_step(load_q, add_pulse, rem_pulse);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_BOARDING;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and settle counter; overload check wins in BOARDING/READY
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      case (state_q)
         S_BOARDING: begin
            if (over_limit) begin
               state_d = S_OVERLOAD;
            end else if (door_closed) begin
               state_d = S_READY;
            end
         end
         S_READY: begin
            if (over_limit) begin
               state_d = S_OVERLOAD;
            end else if (!door_closed) begin
               state_d = S_BOARDING;
            end else if (depart_req) begin
               state_d = S_MOVING;
            end
         end
         S_OVERLOAD: begin
            settle_d = '0;
            if (!over_limit) begin
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (over_limit) begin
               state_d  = S_OVERLOAD;
               settle_d = '0;
            end else if (settle_q == SETTLE_LAST) begin
               state_d  = S_BOARDING;
               settle_d = '0;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end
         S_MOVING: begin
            if (motion_done) begin
               state_d = S_BOARDING;
            end
         end
         default: begin
            state_d  = S_BOARDING;
            settle_d = '0;
         end
      endcase
   end

   // Output decode from the upcoming state so outputs line up with the state
   always_comb begin
      limit_d     = (state_d == S_OVERLOAD) || (state_d == S_SETTLE);
      grant_d     = (state_d == S_MOVING);
      alarm_d     = 1'b0;
      alarm_cnt_d = '0;
      if (state_d == S_OVERLOAD) begin
         if (state_q != S_OVERLOAD) begin
            alarm_d     = 1'b1;
            alarm_cnt_d = '0;
         end else if (alarm_cnt_q == HALF_LAST) begin
            alarm_d     = ~alarm_q;
            alarm_cnt_d = '0;
         end else begin
            alarm_d     = alarm_q;
            alarm_cnt_d = alarm_cnt_q + 1'b1;
         end
      end
   end

   // Counters and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         load_q      <= '0;
         settle_q    <= '0;
         alarm_cnt_q <= '0;
         alarm_q     <= 1'b0;
         limit_q     <= 1'b0;
         grant_q     <= 1'b0;
      end else begin
         load_q      <= load_d;
         settle_q    <= settle_d;
         alarm_cnt_q <= alarm_cnt_d;
         alarm_q     <= alarm_d;
         limit_q     <= limit_d;
         grant_q     <= grant_d;
      end
   end

   assign load_count            = load_q;
   assign weight_limit_exceeded = limit_q;
   assign door_hold             = limit_q;
   assign alarm                 = alarm_q;
   assign depart_grant          = grant_q;

endmodule

// File: tb/tb_overload_supervisor.sv
// Bench for overload_supervisor: directed scenarios followed by random
// traffic, all outputs compared every cycle with a behavioural model.
module tb_overload_supervisor;

   localparam int MAXL   = 6;
   localparam int HALF   = 4;
   localparam int SETTLE = 3;

   typedef enum int {M_BOARD, M_READY, M_OVL, M_SETTLE, M_MOVE} mstate_t;

   logic       clk;
   logic       rst_n;
   logic       weight_flip;
   logic       unload_flip;
   logic       door_closed;
   logic       depart_req;
   logic       motion_done;
   logic [3:0] load_count;
   logic       weight_limit_exceeded;
   logic       alarm;
   logic       door_hold;
   logic       depart_grant;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   mstate_t m_state = M_BOARD;
   int      m_load = 0;
   int      m_ov_n = 0;
   int      m_set_n = 0;
   bit      m_prev_w = 0, m_prev_u = 0, m_pw = 0, m_pu = 0;
   bit      e_limit = 0, e_alarm = 0, e_grant = 0;

   overload_supervisor #(
      .MAX_LOAD          (MAXL),
      .ALARM_HALF_PERIOD (HALF),
      .SETTLE_CYCLES     (SETTLE)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .weight_flip           (weight_flip),
      .unload_flip           (unload_flip),
      .door_closed           (door_closed),
      .depart_req            (depart_req),
      .motion_done           (motion_done),
      .load_count            (load_count),
      .weight_limit_exceeded (weight_limit_exceeded),
      .alarm                 (alarm),
      .door_hold             (door_hold),
      .depart_grant          (depart_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock of the reference: a flip edge becomes a load unit two cycles
   // after it is sampled; the car state and its outputs follow the rules.
   task automatic model_step();
      int      nl;
      mstate_t ns;
      bit      npw, npu, over;
      if (!rst_n) begin
         m_state = M_BOARD; m_load = 0; m_ov_n = 0; m_set_n = 0;
         m_prev_w = 0; m_prev_u = 0; m_pw = 0; m_pu = 0;
         e_limit = 0; e_alarm = 0; e_grant = 0;
         return;
      end
      npw = weight_flip && !m_prev_w;
      npu = unload_flip && !m_prev_u;
      nl  = m_load;
      if (m_state != M_MOVE) begin
         nl = m_load + int'(m_pw) - int'(m_pu);
         if (nl < 0)  nl = 0;
         if (nl > 15) nl = 15;
      end
      over = (m_load > MAXL);
      ns = m_state;
      case (m_state)
         M_BOARD:  if (over) ns = M_OVL; else if (door_closed) ns = M_READY;
         M_READY:  if (over) ns = M_OVL; else if (!door_closed) ns = M_BOARD;
                   else if (depart_req) ns = M_MOVE;
         M_OVL:    if (!over) ns = M_SETTLE;
         M_SETTLE: if (over) ns = M_OVL; else if (m_set_n + 1 >= SETTLE) ns = M_BOARD;
         M_MOVE:   if (motion_done) ns = M_BOARD;
         default:  ns = M_BOARD;
      endcase
      if (ns == M_SETTLE) m_set_n = (m_state == M_SETTLE) ? m_set_n + 1 : 0;
      if (ns == M_OVL)    m_ov_n  = (m_state == M_OVL) ? m_ov_n + 1 : 0;
      m_prev_w = weight_flip; m_prev_u = unload_flip;
      m_pw = npw; m_pu = npu;
      m_load = nl;
      m_state = ns;
      e_limit = (ns == M_OVL) || (ns == M_SETTLE);
      e_alarm = (ns == M_OVL) && (((m_ov_n / HALF) % 2) == 0);
      e_grant = (ns == M_MOVE);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("load",  load_count,            m_load);
      chk("limit", weight_limit_exceeded, e_limit);
      chk("hold",  door_hold,             e_limit);
      chk("alarm", alarm,                 e_alarm);
      chk("grant", depart_grant,          e_grant);
   endtask

   task automatic flip(input bit w, input bit u);
      weight_flip = w; unload_flip = u;
      tick();
      weight_flip = 1'b0; unload_flip = 1'b0;
      tick();
   endtask

   task automatic wait_state(input mstate_t s, input int lim, input string tag);
      int n = 0;
      while (m_state != s && n < lim) begin
         tick();
         n++;
      end
      if (m_state != s) begin
         errors++;
         $error("FAIL timeout_%s observed state %0d expected %0d", tag, m_state, s);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_load"},  load_count,            0);
      chk({tag, "_limit"}, weight_limit_exceeded, 0);
      chk({tag, "_hold"},  door_hold,             0);
      chk({tag, "_alarm"}, alarm,                 0);
      chk({tag, "_grant"}, depart_grant,          0);
   endtask

   initial begin
      rst_n = 1'b0; weight_flip = 1'b0; unload_flip = 1'b0;
      door_closed = 1'b0; depart_req = 1'b0; motion_done = 1'b0;

      // reset state
      tick(); tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // seven loads in BOARDING -> overload with 4-high/4-low alarm
      repeat (7) flip(1'b1, 1'b0);
      chk("ovl_load7", load_count, 7);
      tick();
      chk("ovl_limit", weight_limit_exceeded, 1);
      chk("ovl_hold", door_hold, 1);
      chk("ovl_alarm0", alarm, 1);
      for (int i = 1; i < 16; i++) begin
         tick();
         chk("ovl_alarm_pattern", alarm, ((i / 4) % 2) == 0);
      end

      // one unload -> three SETTLE cycles then BOARDING
      flip(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("settle_alarm", alarm, 0);
         chk("settle_limit", weight_limit_exceeded, 1);
      end
      tick();
      chk("settle_done_limit", weight_limit_exceeded, 0);
      chk("settle_done_hold", door_hold, 0);

      // add edge on the second SETTLE cycle -> back into OVERLOAD, alarm high
      flip(1'b1, 1'b0);
      wait_state(M_OVL, 10, "ovl_again");
      flip(1'b0, 1'b1);
      wait_state(M_SETTLE, 10, "settle_again");
      weight_flip = 1'b1;
      tick();
      weight_flip = 1'b0;
      tick();
      tick();
      chk("reenter_limit", weight_limit_exceeded, 1);
      chk("reenter_alarm", alarm, 1);
      repeat (3) flip(1'b0, 1'b1);
      wait_state(M_BOARD, 30, "board_at4");

      // departure at load 4, loads during MOVING ignored
      door_closed = 1'b1;
      tick(); tick();
      depart_req = 1'b1;
      wait_state(M_MOVE, 10, "moving");
      chk("move_grant", depart_grant, 1);
      repeat (2) flip(1'b1, 1'b0);
      chk("move_load_frozen", load_count, 4);
      depart_req = 1'b0; door_closed = 1'b0;
      tick();
      motion_done = 1'b1;
      tick();
      motion_done = 1'b0;
      chk("arrive_grant", depart_grant, 0);
      chk("arrive_load", load_count, 4);
      tick();

      // saturation boundaries
      repeat (4) flip(1'b0, 1'b1);
      chk("empty_load", load_count, 0);
      flip(1'b1, 1'b1);
      chk("both_at0", load_count, 0);
      flip(1'b0, 1'b1);
      chk("rem_at0", load_count, 0);
      repeat (15) flip(1'b1, 1'b0);
      chk("full_load", load_count, 15);
      flip(1'b1, 1'b1);
      chk("both_at15", load_count, 15);
      flip(1'b1, 1'b0);
      chk("add_at15", load_count, 15);

      // reset while in OVERLOAD
      tick(); tick();
      chk("pre_rst_limit", weight_limit_exceeded, 1);
      rst_n = 1'b0;
      tick();
      chk_all_zero("rst_ovl");
      rst_n = 1'b1;
      tick();

      // reset while MOVING
      door_closed = 1'b1; depart_req = 1'b1;
      wait_state(M_MOVE, 10, "moving2");
      chk("pre_rst_grant", depart_grant, 1);
      rst_n = 1'b0;
      tick();
      chk_all_zero("rst_move");
      rst_n = 1'b1; door_closed = 1'b0; depart_req = 1'b0;
      tick();

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         rst_n       = ($urandom_range(0, 149) != 0);
         weight_flip = ($urandom_range(0, 2) == 0);
         unload_flip = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 7) == 0) door_closed = ~door_closed;
         depart_req  = ($urandom_range(0, 3) == 0);
         motion_done = ($urandom_range(0, 11) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
